// File: rtl/noc_pkt_injector_pkg.sv
// Shared field widths and FSM encoding for the node-0 packet injector.
package noc_pkt_injector_pkg;

    localparam int X_SIZE_DEF  = 2;
    localparam int Y_SIZE_DEF  = 2;
    localparam int PCK_NUM_DEF = 8;
    localparam int ITER_DEF    = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } state_t;

endpackage

// File: rtl/noc_resp_checker.sv
// Response field extraction, payload/destination check and duplicate scoreboard.
module noc_resp_checker
    import noc_pkt_injector_pkg::*;
#(
    parameter int X_SIZE   = X_SIZE_DEF,
    parameter int Y_SIZE   = Y_SIZE_DEF,
    parameter int PCK_NUM  = PCK_NUM_DEF,
    parameter int ITER     = ITER_DEF,
    parameter int NUM_PKTS = 16
) (
    input  logic                                      clk,
    input  logic                                      rst,
    input  logic                                      clr,
    input  logic                                      active,
    input  logic [X_SIZE+Y_SIZE+PCK_NUM+8*ITER-1:0]   i_data,
    input  logic                                      i_valid,
    output logic                                      good,
    output logic                                      bad
);

    localparam int XY = X_SIZE + Y_SIZE;
    localparam logic [PCK_NUM:0] NPK = NUM_PKTS[PCK_NUM:0];

    logic [XY-1:0]          dest;
    logic [PCK_NUM-1:0]     pnum;
    logic                   fault;
    // Sized to the full packet-number space so any received p indexes safely.
    logic [2**PCK_NUM-1:0]  sb_q;

    function automatic logic [7:0] exp_byte(input logic [PCK_NUM-1:0] p, input int k);
        logic [31:0] s;
        s = 32'(p) + 32'(k);
        return 8'hff - s[7:0];
    endfunction

    always_comb begin
        dest  = i_data[XY-1:0];
        pnum  = i_data[XY +: PCK_NUM];
        fault = (dest != '0) || ({1'b0, pnum} >= NPK) || sb_q[pnum] || !active;
        for (int k = 0; k < ITER; k++) begin
            if (i_data[XY+PCK_NUM+8*k +: 8] != exp_byte(pnum, k)) fault = 1'b1;
        end
        good = i_valid && !fault;
        bad  = i_valid && fault;
    end

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            sb_q <= '0;
        end else if (good) begin
            sb_q[pnum] <= 1'b1;
        end
    end

endmodule

// File: rtl/noc_pkt_injector.sv
// Node-0 traffic initiator: injects NUM_PKTS requests round-robin and checks the responses.
module noc_pkt_injector
    import noc_pkt_injector_pkg::*;
#(
    parameter int X_SIZE   = X_SIZE_DEF,
    parameter int Y_SIZE   = Y_SIZE_DEF,
    parameter int PCK_NUM  = PCK_NUM_DEF,
    parameter int ITER     = ITER_DEF,
    parameter int NUM_PKTS = 16,
    parameter int TIMEOUT  = 1024
) (
    input  logic                                      clk,
    input  logic                                      rst,
    input  logic                                      start,
    output logic [X_SIZE+Y_SIZE+PCK_NUM+8*ITER-1:0]   o_data,
    output logic                                      o_valid,
    input  logic                                      i_ready,
    input  logic [X_SIZE+Y_SIZE+PCK_NUM+8*ITER-1:0]   i_data,
    input  logic                                      i_valid,
    output logic                                      done,
    output logic                                      pass,
    output logic                                      timeout,
    output logic [15:0]                               err_cnt,
    output logic [PCK_NUM:0]                          rx_cnt
);

    localparam int XY    = X_SIZE + Y_SIZE;
    localparam int W     = XY + PCK_NUM + 8*ITER;
    localparam int NODES = 2**XY;
    localparam int TW    = $clog2(TIMEOUT + 1);
    localparam logic [PCK_NUM:0] NPK     = NUM_PKTS[PCK_NUM:0];
    localparam logic [PCK_NUM:0] IDX_ONE = {{PCK_NUM{1'b0}}, 1'b1};
    localparam logic [TW-1:0]    TMO     = TIMEOUT[TW-1:0];

    state_t           state_q, state_d;
    logic [PCK_NUM:0] tx_idx_q;
    logic [TW-1:0]    idle_q;
    logic             start_run, tx_fire, last_tx, rx_all, rx_stall, rx_active;
    logic             rx_good, rx_bad;

    function automatic logic [W-1:0] make_req(input logic [PCK_NUM:0] idx);
        logic [W-1:0] pkt;
        logic [31:0]  dest;
        logic [31:0]  b;
        pkt  = '0;
        // Skip node 0 by folding p onto 1..NODES-1.
        dest = (32'(idx) % 32'(NODES - 1)) + 32'd1;
        pkt[XY-1:0]        = dest[XY-1:0];
        pkt[XY +: PCK_NUM] = idx[PCK_NUM-1:0];
        for (int k = 0; k < ITER; k++) begin
            b = 32'(idx) + 32'(k);
            pkt[XY+PCK_NUM+8*k +: 8] = b[7:0];
        end
        return pkt;
    endfunction

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hffff) ? v : v + 16'd1;
    endfunction

    noc_resp_checker #(
        .X_SIZE   (X_SIZE),
        .Y_SIZE   (Y_SIZE),
        .PCK_NUM  (PCK_NUM),
        .ITER     (ITER),
        .NUM_PKTS (NUM_PKTS)
    ) u_checker (
        .clk     (clk),
        .rst     (rst),
        .clr     (start_run),
        .active  (rx_active),
        .i_data  (i_data),
        .i_valid (i_valid),
        .good    (rx_good),
        .bad     (rx_bad)
    );

    always_comb begin
        start_run = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
        tx_fire   = o_valid && i_ready;
        last_tx   = tx_fire && (tx_idx_q == NPK);
        rx_all    = (state_q == ST_WAIT) && (rx_cnt == NPK);
        rx_stall  = (state_q == ST_WAIT) && (idle_q == TMO);
        rx_active = (state_q == ST_SEND) || (state_q == ST_WAIT);
        state_d   = state_q;
        case (state_q)
            ST_IDLE, ST_DONE: if (start)              state_d = ST_SEND;
            ST_SEND:          if (last_tx)            state_d = ST_WAIT;
            ST_WAIT:          if (rx_all || rx_stall) state_d = ST_DONE;
            default:                                  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            o_data   <= '0;
            o_valid  <= 1'b0;
            tx_idx_q <= '0;
            idle_q   <= '0;
            rx_cnt   <= '0;
            err_cnt  <= '0;
            done     <= 1'b0;
            timeout  <= 1'b0;
        end else if (start_run) begin
            o_data   <= make_req('0);
            o_valid  <= 1'b1;
            tx_idx_q <= IDX_ONE;
            idle_q   <= '0;
            rx_cnt   <= '0;
            // A response landing with start is still unexpected and counts in the new run.
            err_cnt  <= {15'd0, rx_bad};
            done     <= 1'b0;
            timeout  <= 1'b0;
        end else begin
            if (tx_fire) begin
                if (last_tx) begin
                    o_valid <= 1'b0;
                end else begin
                    o_data   <= make_req(tx_idx_q);
                    tx_idx_q <= tx_idx_q + 1'b1;
                end
            end
            if (rx_good) rx_cnt <= rx_cnt + 1'b1;
            if (rx_bad)  err_cnt <= sat_inc16(err_cnt);
            if (state_q == ST_WAIT) idle_q <= i_valid ? '0 : idle_q + 1'b1;
            if (rx_all) begin
                done <= 1'b1;
            end else if (rx_stall) begin
                done    <= 1'b1;
                timeout <= 1'b1;
            end
        end
    end

    assign pass = done && (err_cnt == 16'd0) && !timeout;

endmodule

// File: tb/tb_noc_pkt_injector.sv
// Bench for noc_pkt_injector: loopback PE model with fault injection and a response scoreboard model.
module tb_noc_pkt_injector;

    localparam int X_SIZE   = 2;
    localparam int Y_SIZE   = 2;
    localparam int PCK_NUM  = 8;
    localparam int ITER     = 4;
    localparam int NUM_PKTS = 16;
    localparam int TIMEOUT  = 1024;
    localparam int XY       = X_SIZE + Y_SIZE;
    localparam int W        = XY + PCK_NUM + 8*ITER;
    localparam int NODES    = 2**XY;
    localparam int RXW      = PCK_NUM + 1;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic             i_ready = 1'b0;
    logic             i_valid = 1'b0;
    logic [W-1:0]     i_data = '0;
    logic [W-1:0]     o_data;
    logic             o_valid, done, pass, timeout;
    logic [15:0]      err_cnt;
    logic [PCK_NUM:0] rx_cnt;

    noc_pkt_injector #(
        .X_SIZE(X_SIZE), .Y_SIZE(Y_SIZE), .PCK_NUM(PCK_NUM), .ITER(ITER),
        .NUM_PKTS(NUM_PKTS), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .rst(rst), .start(start),
        .o_data(o_data), .o_valid(o_valid), .i_ready(i_ready),
        .i_data(i_data), .i_valid(i_valid),
        .done(done), .pass(pass), .timeout(timeout),
        .err_cnt(err_cnt), .rx_cnt(rx_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] d;
        int           due;
    } resp_t;

    resp_t        rq[$];
    logic [W-1:0] tx_data[$];
    int           tx_cyc[$];
    logic [W-1:0] stall_a[$];
    logic [W-1:0] stall_b[$];
    int  cyc = 0;
    bit  pe_en, rand_ready, reverse;
    int  corrupt_p = -1, dup_p = -1, dest7_p = -1;
    bit  model_active;
    bit  seen[NUM_PKTS];
    int  m_err, m_rx, last_rx_cyc;
    int  checks = 0, errors = 0;

    // Request p as the injector must emit it.
    function automatic logic [W-1:0] exp_req(input int p);
        logic [W-1:0] r;
        int           dest;
        logic [7:0]   b;
        r    = '0;
        dest = (p % (NODES - 1)) + 1;
        r[XY-1:0]        = dest[XY-1:0];
        r[XY +: PCK_NUM] = p[PCK_NUM-1:0];
        for (int k = 0; k < ITER; k++) begin
            b = 8'((p + k) % 256);
            r[XY+PCK_NUM+8*k +: 8] = b;
        end
        return r;
    endfunction

    // PE loopback, handshake logging and response-judging model, all at negedge+1.
    initial begin : pe_model
        logic [W-1:0] resp;
        logic [W-1:0] prev_data;
        bit           prev_stall, ok;
        int           p, sel, lat;
        resp_t        t;
        prev_stall = 1'b0;
        prev_data  = '0;
        forever begin
            @(negedge clk); #1;
            cyc++;
            i_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            if (prev_stall && o_valid && !rst) begin
                stall_a.push_back(prev_data);
                stall_b.push_back(o_data);
            end
            prev_stall = !rst && o_valid && !i_ready;
            prev_data  = o_data;
            if (!rst && o_valid && i_ready) begin
                tx_data.push_back(o_data);
                tx_cyc.push_back(cyc);
                p    = int'(o_data[XY +: PCK_NUM]);
                resp = '0;
                resp[XY +: PCK_NUM] = o_data[XY +: PCK_NUM];
                for (int k = 0; k < ITER; k++)
                    resp[XY+PCK_NUM+8*k +: 8] = 8'hff - o_data[XY+PCK_NUM+8*k +: 8];
                if (p == corrupt_p)
                    resp[XY+PCK_NUM+16 +: 8] = resp[XY+PCK_NUM+16 +: 8] ^ 8'h5a;
                lat = reverse ? 3 + 2*(3 - (p % 4)) : 3;
                if (pe_en) begin
                    t.d = resp; t.due = cyc + lat; rq.push_back(t);
                    if (p == dup_p) begin
                        t.due = cyc + lat + 1; rq.push_back(t);
                    end
                    if (p == dest7_p) begin
                        t.d[XY-1:0] = 4'h7; t.due = cyc + lat + 2; rq.push_back(t);
                    end
                end
            end
            sel = -1;
            for (int i = 0; i < rq.size(); i++)
                if (rq[i].due <= cyc && (sel < 0 || rq[i].due < rq[sel].due)) sel = i;
            if (sel >= 0) begin
                i_valid = 1'b1;
                i_data  = rq[sel].d;
                rq.delete(sel);
                last_rx_cyc = cyc;
                p  = int'(i_data[XY +: PCK_NUM]);
                ok = model_active && (i_data[XY-1:0] == '0) && (p < NUM_PKTS);
                if (ok)
                    for (int k = 0; k < ITER; k++)
                        if (i_data[XY+PCK_NUM+8*k +: 8] != 8'(255 - ((p + k) % 256))) ok = 1'b0;
                if (ok && seen[p]) ok = 1'b0;
                if (ok) begin
                    seen[p] = 1'b1;
                    m_rx++;
                end else if (m_err < 65535) begin
                    m_err++;
                end
            end else begin
                i_valid = 1'b0;
                i_data  = '0;
            end
        end
    end

    task automatic set_mode(input bit pe, input bit rr, input bit rev, input int cp, input int dp, input int d7);
        pe_en = pe; rand_ready = rr; reverse = rev;
        corrupt_p = cp; dup_p = dp; dest7_p = d7;
    endtask

    task automatic do_start();
        rq.delete(); tx_data.delete(); tx_cyc.delete(); stall_a.delete(); stall_b.delete();
        foreach (seen[i]) seen[i] = 1'b0;
        m_err = 0; m_rx = 0; model_active = 1'b1;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
    endtask

    task automatic wait_done(input int budget, output bit got);
        got = 1'b0;
        for (int i = 0; i < budget && !got; i++) begin
            @(negedge clk); #3;
            got = done;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        #3;
        checks++;
        if ({o_valid, done, pass, timeout} !== 4'b0000) begin
            errors++; $display("FAIL reset_flags got %b want 0000", {o_valid, done, pass, timeout});
        end
        checks++;
        if (o_data !== '0) begin errors++; $display("FAIL reset_o_data got %h want 0", o_data); end
        checks++;
        if (err_cnt !== 16'd0 || rx_cnt !== '0) begin
            errors++; $display("FAIL reset_counters got err %0d rx %0d want 0 0", err_cnt, rx_cnt);
        end
        @(negedge clk); rst = 1'b0;
        repeat (2) @(negedge clk);
        #3;
        checks++;
        if (o_valid !== 1'b0 || done !== 1'b0) begin
            errors++; $display("FAIL idle_after_reset got valid %b done %b want 0 0", o_valid, done);
        end
    endtask

    task automatic test_loopback();
        bit got;
        set_mode(1, 0, 0, -1, -1, -1);
        do_start();
        wait_done(400, got);
        checks++;
        if (!got) begin errors++; $display("FAIL loop_done got 0 want 1"); end
        checks++;
        if (tx_data.size() != NUM_PKTS) begin
            errors++; $display("FAIL loop_tx_count got %0d want %0d", tx_data.size(), NUM_PKTS);
        end
        for (int i = 0; i < tx_data.size() && i < NUM_PKTS; i++) begin
            checks++;
            if (tx_data[i] !== exp_req(i)) begin
                errors++; $display("FAIL loop_req[%0d] got %h want %h", i, tx_data[i], exp_req(i));
            end
        end
        checks++;
        if (tx_cyc.size() == 0 || tx_cyc[tx_cyc.size()-1] - tx_cyc[0] != NUM_PKTS - 1) begin
            errors++; $display("FAIL loop_consecutive got span %0d want %0d",
                               (tx_cyc.size() == 0) ? -1 : tx_cyc[tx_cyc.size()-1] - tx_cyc[0], NUM_PKTS - 1);
        end
        checks++;
        if (pass !== 1'b1 || timeout !== 1'b0) begin
            errors++; $display("FAIL loop_pass got pass %b timeout %b want 1 0", pass, timeout);
        end
        checks++;
        if (rx_cnt !== RXW'(NUM_PKTS) || rx_cnt !== RXW'(m_rx) || err_cnt !== 16'(m_err) || err_cnt !== 16'd0) begin
            errors++; $display("FAIL loop_counts got rx %0d err %0d want rx %0d err 0", rx_cnt, err_cnt, NUM_PKTS);
        end
        repeat (5) @(negedge clk);
        #3;
        checks++;
        if (done !== 1'b1 || pass !== 1'b1 || rx_cnt !== RXW'(NUM_PKTS)) begin
            errors++; $display("FAIL done_hold got done %b pass %b rx %0d want 1 1 %0d", done, pass, rx_cnt, NUM_PKTS);
        end
    endtask

    task automatic test_random_ready();
        bit got;
        set_mode(1, 1, 0, -1, -1, -1);
        do_start();
        repeat (3) @(negedge clk);
        start = 1'b1;
        @(negedge clk); start = 1'b0;
        wait_done(600, got);
        checks++;
        if (!got) begin errors++; $display("FAIL rr_done got 0 want 1"); end
        checks++;
        if (tx_data.size() != NUM_PKTS) begin
            errors++; $display("FAIL rr_tx_count got %0d want %0d", tx_data.size(), NUM_PKTS);
        end
        for (int i = 0; i < tx_data.size() && i < NUM_PKTS; i++) begin
            checks++;
            if (tx_data[i] !== exp_req(i)) begin
                errors++; $display("FAIL rr_req[%0d] got %h want %h", i, tx_data[i], exp_req(i));
            end
        end
        for (int i = 0; i < stall_a.size(); i++) begin
            checks++;
            if (stall_b[i] !== stall_a[i]) begin
                errors++; $display("FAIL rr_stall_stable[%0d] got %h want %h", i, stall_b[i], stall_a[i]);
            end
        end
        checks++;
        if (pass !== 1'b1 || rx_cnt !== RXW'(NUM_PKTS) || err_cnt !== 16'(m_err)) begin
            errors++; $display("FAIL rr_pass got pass %b rx %0d err %0d want 1 %0d %0d", pass, rx_cnt, err_cnt, NUM_PKTS, m_err);
        end
    endtask

    task automatic test_corrupt_timeout();
        bit got;
        int gap;
        set_mode(1, 0, 0, 5, -1, -1);
        do_start();
        wait_done(TIMEOUT + 300, got);
        gap = cyc - last_rx_cyc;
        checks++;
        if (!got) begin errors++; $display("FAIL to_done got 0 want 1"); end
        checks++;
        if (err_cnt !== 16'd1 || err_cnt !== 16'(m_err)) begin
            errors++; $display("FAIL to_err_cnt got %0d want 1 (model %0d)", err_cnt, m_err);
        end
        checks++;
        if (rx_cnt !== RXW'(NUM_PKTS - 1) || rx_cnt !== RXW'(m_rx)) begin
            errors++; $display("FAIL to_rx_cnt got %0d want %0d", rx_cnt, NUM_PKTS - 1);
        end
        checks++;
        if (timeout !== 1'b1 || pass !== 1'b0) begin
            errors++; $display("FAIL to_flags got timeout %b pass %b want 1 0", timeout, pass);
        end
        checks++;
        if (gap < TIMEOUT || gap > TIMEOUT + 4) begin
            errors++; $display("FAIL to_idle_span got %0d want %0d..%0d", gap, TIMEOUT, TIMEOUT + 4);
        end
    endtask

    task automatic test_dup_baddest();
        bit got;
        set_mode(1, 0, 0, -1, 3, 10);
        do_start();
        wait_done(400, got);
        checks++;
        if (!got) begin errors++; $display("FAIL dup_done got 0 want 1"); end
        checks++;
        if (err_cnt !== 16'd2 || err_cnt !== 16'(m_err)) begin
            errors++; $display("FAIL dup_err_cnt got %0d want 2 (model %0d)", err_cnt, m_err);
        end
        checks++;
        if (pass !== 1'b0 || timeout !== 1'b0 || rx_cnt !== RXW'(NUM_PKTS)) begin
            errors++; $display("FAIL dup_flags got pass %b timeout %b rx %0d want 0 0 %0d", pass, timeout, rx_cnt, NUM_PKTS);
        end
    endtask

    task automatic test_reorder();
        bit got, overlap;
        set_mode(1, 0, 1, -1, -1, -1);
        do_start();
        got = 1'b0; overlap = 1'b0;
        for (int i = 0; i < 400 && !got; i++) begin
            @(negedge clk); #3;
            if (o_valid && rx_cnt != '0) overlap = 1'b1;
            got = done;
        end
        checks++;
        if (!overlap) begin errors++; $display("FAIL ro_overlap got 0 want 1"); end
        checks++;
        if (!got || pass !== 1'b1) begin errors++; $display("FAIL ro_pass got done %b pass %b want 1 1", got, pass); end
        checks++;
        if (rx_cnt !== RXW'(m_rx) || err_cnt !== 16'(m_err) || m_rx != NUM_PKTS) begin
            errors++; $display("FAIL ro_counts got rx %0d err %0d want %0d %0d", rx_cnt, err_cnt, m_rx, m_err);
        end
    endtask

    task automatic test_reset_mid_send();
        bit got;
        resp_t t;
        set_mode(0, 0, 0, -1, -1, -1);
        do_start();
        for (int i = 0; i < 50 && tx_data.size() < 6; i++) begin
            @(negedge clk); #3;
        end
        @(negedge clk);
        rst = 1'b1; model_active = 1'b0; m_err = 0; m_rx = 0;
        @(negedge clk);
        rst = 1'b0;
        #3;
        checks++;
        if (o_valid !== 1'b0 || done !== 1'b0 || o_data !== '0) begin
            errors++; $display("FAIL rst_mid_outputs got valid %b done %b data %h want 0 0 0", o_valid, done, o_data);
        end
        checks++;
        if (err_cnt !== 16'd0 || rx_cnt !== '0 || tx_data.size() != 6) begin
            errors++; $display("FAIL rst_mid_counts got err %0d rx %0d tx %0d want 0 0 6", err_cnt, rx_cnt, tx_data.size());
        end
        t.d = '0;
        t.d[XY +: PCK_NUM] = 8'd2;
        for (int k = 0; k < ITER; k++) t.d[XY+PCK_NUM+8*k +: 8] = 8'(255 - (2 + k));
        t.due = cyc + 1;
        rq.push_back(t);
        repeat (4) @(negedge clk);
        #3;
        checks++;
        if (err_cnt !== 16'd1 || err_cnt !== 16'(m_err) || rx_cnt !== '0) begin
            errors++; $display("FAIL stale_resp got err %0d rx %0d want 1 0", err_cnt, rx_cnt);
        end
        set_mode(1, 0, 0, -1, -1, -1);
        do_start();
        wait_done(400, got);
        checks++;
        if (!got || pass !== 1'b1 || rx_cnt !== RXW'(NUM_PKTS) || err_cnt !== 16'd0) begin
            errors++; $display("FAIL rerun_pass got done %b pass %b rx %0d err %0d want 1 1 %0d 0", got, pass, rx_cnt, err_cnt, NUM_PKTS);
        end
        checks++;
        if (tx_data.size() != NUM_PKTS || tx_data[0] !== exp_req(0)) begin
            errors++; $display("FAIL rerun_first_req got count %0d want %0d", tx_data.size(), NUM_PKTS);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        set_mode(0, 0, 0, -1, -1, -1);
        model_active = 1'b0;
        m_err = 0; m_rx = 0; last_rx_cyc = 0;
        test_reset();
        test_loopback();
        test_random_ready();
        test_corrupt_timeout();
        test_dup_baddest();
        test_reorder();
        test_reset_mid_send();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
